pipe_stage_regs: RTL and testbench

//  PC, IF/ID and ID/EX pipeline registers of the 5-stage RV32I core; the receiving end of the load-use hazard controls.

---
 rtl/riscv_pipe_pkg.sv | 44 ++++
 rtl/pipe_reg.sv | 33 +++
 rtl/pipe_stage_regs.sv | 175 +++++++++++++++++
 tb/tb_pipe_stage_regs.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared types and constants for the RV32I pipeline registers:
//               write-back select encodings, decoded control bundle, NOP and
//               bubble control values.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    // Write-back source select. WB_MEM (00) is the encoding the hazard unit
    // treats as "E stage is a load".
    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Decoded control bundle carried from D into E.
    typedef struct packed {
        logic [1:0] sel_wb;
        logic       reg_wr;
        logic       mem_wr;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       branch;
        logic       jump;
    } pipe_ctrl_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A bubble writes nothing and selects the ALU result so it can never be
    // mistaken for a load by the load-use detector.
    localparam pipe_ctrl_t CTRL_BUBBLE = '{
        sel_wb   : WB_ALU,
        reg_wr   : 1'b0,
        mem_wr   : 1'b0,
        alu_ctrl : 4'h0,
        alu_src  : 1'b0,
        branch   : 1'b0,
        jump     : 1'b0
    };

endpackage : riscv_pipe_pkg
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Generic pipeline register with synchronous active-low reset,
//               synchronous clear (higher priority) and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  T     rst_val,
    input  T     clr_val,
    input  T     d,
    output T     q
);

    // Reset beats clear, clear beats enable; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= rst_val;
        end else if (clr) begin
            q <= clr_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_reg
`default_nettype wire

// File: rtl/pipe_stage_regs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_regs
// Description : PC, IF/ID and ID/EX pipeline registers of the 5-stage RV32I
//               core with stall/flush handling and stall/flush performance
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_regs
    import riscv_pipe_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              flushE,
    input  logic [XLEN-1:0]   pc_next_F,
    output logic [XLEN-1:0]   pc_F,
    input  logic [31:0]       instr_F,
    input  logic [XLEN-1:0]   pc_plus4_F,
    output logic [31:0]       instr_D,
    output logic [XLEN-1:0]   pc_D,
    output logic [XLEN-1:0]   pc_plus4_D,
    input  logic [4:0]        rs1_addr_D,
    input  logic [4:0]        rs2_addr_D,
    input  logic [4:0]        rd_D,
    input  pipe_ctrl_t        ctrl_D,
    input  logic [XLEN-1:0]   rd1_D,
    input  logic [XLEN-1:0]   rd2_D,
    input  logic [XLEN-1:0]   imm_ext_D,
    output logic [4:0]        rs1_addr_E,
    output logic [4:0]        rs2_addr_E,
    output logic [4:0]        rd_E,
    output pipe_ctrl_t        ctrl_E,
    output logic [1:0]        sel_wb_E,
    output logic [XLEN-1:0]   rd1_E,
    output logic [XLEN-1:0]   rd2_E,
    output logic [XLEN-1:0]   imm_ext_E,
    output logic [XLEN-1:0]   pc_E,
    output logic [XLEN-1:0]   pc_plus4_E,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef logic [XLEN-1:0] pc_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } ifid_t;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        pipe_ctrl_t      ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } idex_t;

    localparam pc_t   c_reset_pc = pc_t'(RESET_PC);
    localparam ifid_t c_ifid_nop = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
    localparam idex_t c_idex_bubble = '{
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, ctrl: CTRL_BUBBLE,
        rd1: '0, rd2: '0, imm: '0, pc: '0, pc_plus4: '0
    };

    ifid_t w_ifid_d;
    ifid_t r_ifid_q;
    idex_t w_idex_d;
    idex_t r_idex_q;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // PC register: no clear, stallF holds.
    pipe_reg #(.T(pc_t)) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (~stallF),
        .clr     (1'b0),
        .rst_val (c_reset_pc),
        .clr_val (c_reset_pc),
        .d       (pc_next_F),
        .q       (pc_F)
    );

    // IF/ID captures the fetch-side values; clear (flushD) wins over hold.
    always_comb begin
        w_ifid_d          = c_ifid_nop;
        w_ifid_d.instr    = instr_F;
        w_ifid_d.pc       = pc_F;
        w_ifid_d.pc_plus4 = pc_plus4_F;
    end

    pipe_reg #(.T(ifid_t)) u_ifid_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (~stallD),
        .clr     (flushD),
        .rst_val (c_ifid_nop),
        .clr_val (c_ifid_nop),
        .d       (w_ifid_d),
        .q       (r_ifid_q)
    );

    assign instr_D    = r_ifid_q.instr;
    assign pc_D       = r_ifid_q.pc;
    assign pc_plus4_D = r_ifid_q.pc_plus4;

    // ID/EX bundles the decoded D stage; E never stalls, flushE inserts a bubble.
    always_comb begin
        w_idex_d          = c_idex_bubble;
        w_idex_d.rs1      = rs1_addr_D;
        w_idex_d.rs2      = rs2_addr_D;
        w_idex_d.rd       = rd_D;
        w_idex_d.ctrl     = ctrl_D;
        w_idex_d.rd1      = rd1_D;
        w_idex_d.rd2      = rd2_D;
        w_idex_d.imm      = imm_ext_D;
        w_idex_d.pc       = r_ifid_q.pc;
        w_idex_d.pc_plus4 = r_ifid_q.pc_plus4;
    end

    pipe_reg #(.T(idex_t)) u_idex_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (1'b1),
        .clr     (flushE),
        .rst_val (c_idex_bubble),
        .clr_val (c_idex_bubble),
        .d       (w_idex_d),
        .q       (r_idex_q)
    );

    assign rs1_addr_E = r_idex_q.rs1;
    assign rs2_addr_E = r_idex_q.rs2;
    assign rd_E       = r_idex_q.rd;
    assign ctrl_E     = r_idex_q.ctrl;
    assign sel_wb_E   = r_idex_q.ctrl.sel_wb;
    assign rd1_E      = r_idex_q.rd1;
    assign rd2_E      = r_idex_q.rd2;
    assign imm_ext_E  = r_idex_q.imm;
    assign pc_E       = r_idex_q.pc;
    assign pc_plus4_E = r_idex_q.pc_plus4;

    // Free-running wrap-around counters of stall and flush cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stallD) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flushD || flushE) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule : pipe_stage_regs
`default_nettype wire

// File: tb/tb_pipe_stage_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_regs
// Description : Self-checking bench for pipe_stage_regs with a cycle-level
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_regs;
    import riscv_pipe_pkg::*;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, stallF, stallD, flushD, flushE;
    logic [XLEN-1:0] pc_next_F, pc_F, pc_plus4_F, pc_D, pc_plus4_D;
    logic [31:0] instr_F, instr_D;
    logic [4:0] rs1_addr_D, rs2_addr_D, rd_D, rs1_addr_E, rs2_addr_E, rd_E;
    pipe_ctrl_t ctrl_D, ctrl_E;
    logic [1:0] sel_wb_E;
    logic [XLEN-1:0] rd1_D, rd2_D, imm_ext_D, rd1_E, rd2_E, imm_ext_E, pc_E, pc_plus4_E;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_stage_regs #(.XLEN(XLEN), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD),
        .flushD(flushD), .flushE(flushE), .pc_next_F(pc_next_F), .pc_F(pc_F),
        .instr_F(instr_F), .pc_plus4_F(pc_plus4_F), .instr_D(instr_D),
        .pc_D(pc_D), .pc_plus4_D(pc_plus4_D), .rs1_addr_D(rs1_addr_D),
        .rs2_addr_D(rs2_addr_D), .rd_D(rd_D), .ctrl_D(ctrl_D), .rd1_D(rd1_D),
        .rd2_D(rd2_D), .imm_ext_D(imm_ext_D), .rs1_addr_E(rs1_addr_E),
        .rs2_addr_E(rs2_addr_E), .rd_E(rd_E), .ctrl_E(ctrl_E),
        .sel_wb_E(sel_wb_E), .rd1_E(rd1_E), .rd2_E(rd2_E),
        .imm_ext_E(imm_ext_E), .pc_E(pc_E), .pc_plus4_E(pc_plus4_E),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: what each architectural stage should hold.
    logic [XLEN-1:0] m_pc, m_pcD, m_pc4D;
    logic [31:0]     m_instrD;
    logic [4:0]      m_rs1E, m_rs2E, m_rdE;
    pipe_ctrl_t      m_ctrlE;
    logic [XLEN-1:0] m_rd1E, m_rd2E, m_immE, m_pcE, m_pc4E;
    int              m_stalls, m_flushes;

    task automatic model_bubble_e();
        m_rs1E = 5'd0; m_rs2E = 5'd0; m_rdE = 5'd0; m_ctrlE = CTRL_BUBBLE;
        m_rd1E = '0; m_rd2E = '0; m_immE = '0; m_pcE = '0; m_pc4E = '0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        if (!rst_n) begin
            m_pc = RESET_PC; m_instrD = NOP_INSTR; m_pcD = '0; m_pc4D = '0;
            model_bubble_e();
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (flushE) model_bubble_e();
            else begin
                m_rs1E = rs1_addr_D; m_rs2E = rs2_addr_D; m_rdE = rd_D;
                m_ctrlE = ctrl_D; m_rd1E = rd1_D; m_rd2E = rd2_D;
                m_immE = imm_ext_D; m_pcE = m_pcD; m_pc4E = m_pc4D;
            end
            if (flushD) begin
                m_instrD = NOP_INSTR; m_pcD = '0; m_pc4D = '0;
            end else if (!stallD) begin
                m_instrD = instr_F; m_pcD = m_pc; m_pc4D = pc_plus4_F;
            end
            if (!stallF) m_pc = pc_next_F;
            m_stalls  = (m_stalls + (stallD ? 1 : 0)) % (1 << CNT_W);
            m_flushes = (m_flushes + ((flushD || flushE) ? 1 : 0)) % (1 << CNT_W);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [323:0] dut_vec();
        return {pc_F, instr_D, pc_D, pc_plus4_D, rs1_addr_E, rs2_addr_E, rd_E,
                ctrl_E, sel_wb_E, rd1_E, rd2_E, imm_ext_E, pc_E, pc_plus4_E,
                stall_cnt, flush_cnt};
    endfunction

    function automatic logic [323:0] model_vec();
        return {m_pc, m_instrD, m_pcD, m_pc4D, m_rs1E, m_rs2E, m_rdE,
                m_ctrlE, m_ctrlE.sel_wb, m_rd1E, m_rd2E, m_immE, m_pcE, m_pc4E,
                CNT_W'(m_stalls), CNT_W'(m_flushes)};
    endfunction

    task automatic drive_idle();
        stallF = 0; stallD = 0; flushD = 0; flushE = 0;
    endtask

    task automatic randomize_data();
        pc_next_F = $urandom; instr_F = $urandom; pc_plus4_F = $urandom;
        rs1_addr_D = 5'($urandom); rs2_addr_D = 5'($urandom); rd_D = 5'($urandom);
        ctrl_D = pipe_ctrl_t'($urandom);
        rd1_D = $urandom; rd2_D = $urandom; imm_ext_D = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 0; drive_idle(); randomize_data();
        tick(); tick();
        rst_n = 1;
        tests_run++;
        if ({pc_F, instr_D, sel_wb_E, rd_E, stall_cnt, flush_cnt} !==
            {RESET_PC, 32'h0000_0013, 2'b01, 5'd0, 4'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: pc_F=%h instr_D=%h sel_wb_E=%b rd_E=%0d cnt=%0d/%0d, want 0/13/01/0/0/0",
                     pc_F, instr_D, sel_wb_E, rd_E, stall_cnt, flush_cnt);
        end
        tests_run++;
        if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL reset_model: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_sequence();
        logic [31:0] instrs [3];
        logic [4:0]  rds [3];
        instrs[0] = 32'h0000_000A; instrs[1] = 32'h0000_000B; instrs[2] = 32'h0000_000C;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            pc_next_F = 32'(4 * (i + 1)); instr_F = instrs[i];
            rd_D = 5'(i + 3); rds[i] = rd_D;
            ctrl_D.sel_wb = WB_PC4;
            tick();
            tests_run++;
            if (instr_D !== instrs[i] || pc_F !== 32'(4 * (i + 1))) begin
                tests_failed++;
                $display("FAIL seq_fetch_lag%0d: instr_D=%h pc_F=%h want %h %h",
                         i, instr_D, pc_F, instrs[i], 32'(4 * (i + 1)));
            end
            if (i > 0) begin
                tests_run++;
                if (rd_E !== rds[i] || ctrl_E.sel_wb !== WB_PC4) begin
                    tests_failed++;
                    $display("FAIL seq_e_lag%0d: rd_E=%0d sel_wb=%b want %0d 10", i, rd_E, ctrl_E.sel_wb, rds[i]);
                end
            end
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL seq_model%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_load_use();
        logic [XLEN-1:0] pc_before;
        drive_idle(); randomize_data();
        instr_F = 32'h0000_000B;
        tick();
        pc_before = pc_F;
        randomize_data();
        ctrl_D.sel_wb = WB_MEM; ctrl_D.reg_wr = 1'b1;
        stallF = 1; stallD = 1; flushE = 1;
        tick();
        tests_run++;
        if (pc_F !== pc_before || instr_D !== 32'h0000_000B || ctrl_E !== CTRL_BUBBLE ||
            stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
            tests_failed++;
            $display("FAIL load_use: pc_F=%h instr_D=%h ctrl_E=%h cnt=%0d/%0d want %h 0000000b %h 1/1",
                     pc_F, instr_D, ctrl_E, stall_cnt, flush_cnt, pc_before, CTRL_BUBBLE);
        end
        drive_idle(); randomize_data();
        tick();
        tests_run++;
        if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL load_use_release: got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_flush_over_stall();
        drive_idle(); randomize_data();
        flushD = 1; stallD = 1; instr_F = 32'hDEAD_BEEF;
        tick();
        tests_run++;
        if (instr_D !== 32'h0000_0013 || pc_D !== '0 || pc_plus4_D !== '0) begin
            tests_failed++;
            $display("FAIL flush_over_stall: instr_D=%h pc_D=%h pc4_D=%h want 00000013 0 0", instr_D, pc_D, pc_plus4_D);
        end
    endtask

    task automatic test_bubble_x0();
        drive_idle(); randomize_data();
        rs1_addr_D = 5'd0; rd_D = 5'd7; ctrl_D.sel_wb = WB_MEM;
        flushE = 1;
        tick();
        tests_run++;
        if (sel_wb_E !== 2'b01 || rd_E !== 5'd0 || rs1_addr_E !== 5'd0 || ctrl_E.reg_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_x0: sel_wb_E=%b rd_E=%0d rs1_E=%0d reg_wr=%b want 01 0 0 0",
                     sel_wb_E, rd_E, rs1_addr_E, ctrl_E.reg_wr);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 300; i++) begin
            randomize_data();
            stallF = ($urandom_range(3) == 0); stallD = ($urandom_range(3) == 0);
            flushD = ($urandom_range(4) == 0); flushE = ($urandom_range(4) == 0);
            rst_n  = ($urandom_range(60) != 0);
            tick();
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                if (errs++ < 5) $display("FAIL random%0d: got %h want %h", i, dut_vec(), model_vec());
            end
        end
        rst_n = 1;
    endtask

    task automatic test_wrap_and_reset();
        rst_n = 0; drive_idle(); tick();
        rst_n = 1; stallD = 1; stallF = 1;
        for (int i = 0; i < 17; i++) tick();
        tests_run++;
        if (stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL counter_wrap: stall_cnt=%0d flush_cnt=%0d want 1 0", stall_cnt, flush_cnt);
        end
        flushD = 1; flushE = 1; rst_n = 0;
        tick();
        tests_run++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || pc_F !== RESET_PC ||
            instr_D !== NOP_INSTR || ctrl_E !== CTRL_BUBBLE) begin
            tests_failed++;
            $display("FAIL reset_mid_stall: cnt=%0d/%0d pc_F=%h instr_D=%h ctrl_E=%h want 0/0 %h 00000013 %h",
                     stall_cnt, flush_cnt, pc_F, instr_D, ctrl_E, RESET_PC, CTRL_BUBBLE);
        end
        rst_n = 1; drive_idle();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_load_use();
        test_flush_over_stall();
        test_bubble_x0();
        test_random();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pipe_stage_regs
`default_nettype wire
